// File: rtl/elastic_pipe_reg.sv
// ============================================================================
// Module   : elastic_pipe_reg
// Purpose  : Flushable valid/ready pipeline-stage register with 2-entry skid
//            buffer, bubble-on-empty control field and saturating statistics.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module elastic_pipe_reg #(
  parameter int                 DATA_W      = 96,
  parameter int                 CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flushed_entries
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_flushed;

  logic              w_acc;
  logic              w_deq;
  logic [1:0]        w_discard;
  logic [CNT_W:0]    w_flush_sum;

  // State encoding doubles as the occupancy count.
  assign occupancy       = r_state;
  assign in_ready        = !Reset && (r_state != ST_TWO);
  assign out_valid       = (r_state != ST_EMPTY);
  assign out_ctrl        = r_main_ctrl;
  assign out_data        = r_main_data;
  assign stall_cycles    = r_stall;
  assign flushed_entries = r_flushed;

  assign w_acc = in_valid && in_ready;
  assign w_deq = out_valid && out_ready;

  // A beat dequeued alongside a flush was consumed downstream, not discarded.
  assign w_discard   = r_state - {1'b0, w_deq};
  assign w_flush_sum = {1'b0, r_flushed} + (CNT_W+1)'(w_discard);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= BUBBLE_CTRL;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      r_stall     <= '0;
      r_flushed   <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall != '1))
        r_stall <= r_stall + 1'b1;

      if (Flush) begin
        r_flushed   <= w_flush_sum[CNT_W] ? '1 : w_flush_sum[CNT_W-1:0];
        r_state     <= ST_EMPTY;
        r_main_ctrl <= BUBBLE_CTRL;
        r_main_data <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_acc) begin
              r_state     <= ST_ONE;
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end
          end
          ST_ONE: begin
            if (w_acc && w_deq) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end else if (w_acc) begin
              r_state     <= ST_TWO;
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
            end else if (w_deq) begin
              r_state     <= ST_EMPTY;
              r_main_ctrl <= BUBBLE_CTRL;
              r_main_data <= '0;
            end
          end
          ST_TWO: begin
            if (w_deq) begin
              r_state     <= ST_ONE;
              r_main_ctrl <= r_skid_ctrl;
              r_main_data <= r_skid_data;
            end
          end
          default: begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= BUBBLE_CTRL;
            r_main_data <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
